sfp_port_bringup_sequencer: RTL and testbench
=============================================

// Module: sfp_port_bringup_sequencer
// PURPOSE
//  Multi-port successor to the single-SFP power-on/reset bring-up. It sits between the SFP cage pins,
//  the per-port XCVR reset controllers and the SGMII PCS/MAC. Each port runs its own supervisor FSM:
//  power-up delay, SFP TX_DISABLE pulse, XCVR reset, link wait, fault retry and latched fault.
// PARAMETERS
//  NUM_PORTS          2          number of SFP ports (1..8)
//  CLOCK_FREQUENCY    125000000  i_clock Hz; must be an integer multiple of 1 MHz, >= 2 MHz (elab assert)
//  POWERUP_DELAY_US   20000      global delay after reset before any port leaves INIT
//  TX_DISABLE_US      10         TX_DISABLE pulse per (re)start; SFP t_reset minimum
//  XCVR_RESET_US      1          o_xcvr_reset assertion width
//  LINK_TIMEOUT_US    100000     timeout in XCVR_WAIT/LINK_WAIT; expiry returns the port to XCVR_RESET
//  FAULT_RETRY_LIMIT  3          consecutive tx_fault events before latching FAULT (1..15)
// PORTS
//  i_clock              in   1   single clock (system/reference clock)
//  i_reset              in   1   synchronous, active-high reset
//  i_sfp_mod_prsnt_n    in   N   module present, active low, asynchronous pin
//  i_sfp_los            in   N   loss of signal, asynchronous pin
//  i_sfp_tx_fault       in   N   transmitter fault, asynchronous pin
//  i_xcvr_ready         in   N   rx_ready & tx_ready from the port XCVR reset controller
//  i_link_up            in   N   PCS link status (sync to i_clock by the PCS wrapper)
//  o_sfp_tx_disable     out  N   SFP TX_DISABLE pin drive
//  o_xcvr_reset         out  N   reset to the port XCVR reset controller
//  o_port_up            out  N   port usable by the MAC
//  o_port_fault         out  N   latched fault; cleared only by module removal or i_reset
//  o_powerup_done       out  1   global power-up delay elapsed
// BEHAVIOUR
//  - Reset: all FSMs go to INIT; tx_disable=all 1, xcvr_reset=all 1, port_up=0, port_fault=0, powerup_done=0.
//    i_reset mid-operation gives these values on the next edge and restarts the power-up delay.
//  - The three SFP pin inputs each pass through a 2-flop synchroniser.
//  - Outputs are a Moore decode of registered state. Pin-to-output latency is 3 clocks.
//  - The 1 us tick is a prescaler of CLOCK_FREQUENCY/1e6 cycles; one pulse per microsecond.
//    Each port has one tick counter, cleared on every state entry. "Elapses" means count == limit-1 on a tick.
//  - Per-port states (tx_dis / xcvr_rst / up / fault):
//    INIT        (1/1/0/0): leave to ABSENT when o_powerup_done=1.
//    ABSENT      (1/1/0/0): present seen -> TX_DISABLE; retry count <= 0.
//    TX_DISABLE  (1/1/0/0): TX_DISABLE_US elapses -> XCVR_RESET.
//    XCVR_RESET  (0/1/0/0): XCVR_RESET_US elapses -> XCVR_WAIT.
//    XCVR_WAIT   (0/0/0/0): i_xcvr_ready -> LINK_WAIT; timeout -> XCVR_RESET.
//    LINK_WAIT   (0/0/0/0): i_link_up & !los -> UP; timeout -> XCVR_RESET; LOS alone is not an exit.
//    UP          (0/0/1/0): los or !link_up -> LINK_WAIT; !xcvr_ready -> XCVR_WAIT.
//    FAULT       (1/1/0/1): exits only on removal.
//  - tx_fault in XCVR_RESET..UP increments the retry count. If the count reaches FAULT_RETRY_LIMIT -> FAULT,
//    else -> TX_DISABLE. The retry count clears only in ABSENT, so faults accumulate across UP periods.
//  - Priority per cycle: removal (prsnt_n=1, any state except INIT) -> ABSENT
//    > tx_fault > xcvr_ready loss > los/link > timers.
//  - Ports are fully independent. Same-cycle events on different ports are all honoured.
//  - o_powerup_done rises once after POWERUP_DELAY_US and stays high until i_reset.
// STRUCTURE
//  - Package sfp_bringup_pkg: port_state_t enum (8 states, 3-bit), us_to_ticks() function,
//    timer width constant $clog2(max(all *_US)+1).
//  - Sub-module us_tick_generator (i_clock, i_reset, o_tick): shared by the global and per-port timers.
//  - Per-port FSM in a generate loop.
// TESTING (sim: CLOCK_FREQUENCY=10e6, POWERUP_DELAY_US=5, TX_DISABLE_US=10, LINK_TIMEOUT_US=50, limit=3)
//  - Bring-up: present=0 from reset, xcvr_ready 20us after XCVR_RESET, link 5us later
//    -> powerup_done at cycle 50+1, tx_disable low at ~150, port_up high.
//  - LOS in UP -> port_up low within 3 clocks; LOS clear + link_up -> UP; tx_disable stays 0.
//  - 3 tx_fault pulses, each after restart -> two 10us TX_DISABLE pulses, then fault=1, tx_disable=1;
//    removal clears fault; reinsert restarts.
//  - No i_link_up -> XCVR_RESET reasserted every 50us + 1us; never FAULT.
//  - Removal and tx_fault in the same cycle -> ABSENT; retry count 0, no fault.
//  - i_reset in UP on port1 while port0 is in TX_DISABLE -> all outputs at reset values next edge;
//    full delay replayed.

Source files
------------

// File: rtl/sfp_bringup_pkg.sv
// Shared state encoding and elaboration helpers for the SFP port bring-up sequencer.
package sfp_bringup_pkg;

    typedef logic [2:0] port_state_t;

    localparam port_state_t StInit      = 3'd0;
    localparam port_state_t StAbsent    = 3'd1;
    localparam port_state_t StTxDisable = 3'd2;
    localparam port_state_t StXcvrReset = 3'd3;
    localparam port_state_t StXcvrWait  = 3'd4;
    localparam port_state_t StLinkWait  = 3'd5;
    localparam port_state_t StUp        = 3'd6;
    localparam port_state_t StFault     = 3'd7;

    localparam int unsigned RetryWidth = 4;

    function automatic int unsigned us_to_ticks(input int unsigned freq_hz);
        return freq_hz / 1_000_000;
    endfunction

    function automatic int unsigned timer_width(input int unsigned a, input int unsigned b,
                                                input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/us_tick_generator.sv
// Free-running prescaler producing a single-cycle pulse once per microsecond.
module us_tick_generator
    import sfp_bringup_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY = 125_000_000
) (
    input  logic i_clock,
    input  logic i_reset,
    output logic o_tick
);
    localparam int unsigned Divide     = us_to_ticks(CLOCK_FREQUENCY);
    localparam int unsigned CountWidth = $clog2(Divide);

    logic [CountWidth-1:0] count_q;

    assign o_tick = (count_q == CountWidth'(Divide - 1));

    always_ff @(posedge i_clock) begin
        if (i_reset || o_tick) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + CountWidth'(1);
        end
    end

endmodule

// File: rtl/sfp_port_bringup_sequencer.sv
// Multi-port SFP bring-up supervisor: global power-up delay, shared 1 us tick, one FSM per port.
module sfp_port_bringup_sequencer
    import sfp_bringup_pkg::*;
#(
    parameter int unsigned NUM_PORTS         = 2,
    parameter int unsigned CLOCK_FREQUENCY   = 125_000_000,
    parameter int unsigned POWERUP_DELAY_US  = 20_000,
    parameter int unsigned TX_DISABLE_US     = 10,
    parameter int unsigned XCVR_RESET_US     = 1,
    parameter int unsigned LINK_TIMEOUT_US   = 100_000,
    parameter int unsigned FAULT_RETRY_LIMIT = 3
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic [NUM_PORTS-1:0] i_sfp_mod_prsnt_n,
    input  logic [NUM_PORTS-1:0] i_sfp_los,
    input  logic [NUM_PORTS-1:0] i_sfp_tx_fault,
    input  logic [NUM_PORTS-1:0] i_xcvr_ready,
    input  logic [NUM_PORTS-1:0] i_link_up,
    output logic [NUM_PORTS-1:0] o_sfp_tx_disable,
    output logic [NUM_PORTS-1:0] o_xcvr_reset,
    output logic [NUM_PORTS-1:0] o_port_up,
    output logic [NUM_PORTS-1:0] o_port_fault,
    output logic                 o_powerup_done
);
    localparam int unsigned TimerWidth =
        timer_width(POWERUP_DELAY_US, TX_DISABLE_US, XCVR_RESET_US, LINK_TIMEOUT_US);

    localparam logic [TimerWidth-1:0] PowerupLast     = TimerWidth'(POWERUP_DELAY_US - 1);
    localparam logic [TimerWidth-1:0] TxDisableLast   = TimerWidth'(TX_DISABLE_US - 1);
    localparam logic [TimerWidth-1:0] XcvrResetLast   = TimerWidth'(XCVR_RESET_US - 1);
    localparam logic [TimerWidth-1:0] LinkTimeoutLast = TimerWidth'(LINK_TIMEOUT_US - 1);
    localparam logic [RetryWidth-1:0] RetryLimit      = RetryWidth'(FAULT_RETRY_LIMIT);

    if (CLOCK_FREQUENCY % 1_000_000 != 0 || CLOCK_FREQUENCY < 2_000_000 ||
        NUM_PORTS < 1 || NUM_PORTS > 8 ||
        FAULT_RETRY_LIMIT < 1 || FAULT_RETRY_LIMIT > 15) begin : g_bad_params
        $error("sfp_port_bringup_sequencer: illegal parameter value");
    end

    logic us_tick;

    us_tick_generator #(
        .CLOCK_FREQUENCY(CLOCK_FREQUENCY)
    ) u_us_tick (
        .i_clock(i_clock),
        .i_reset(i_reset),
        .o_tick (us_tick)
    );

    // Global power-up delay; the done flag is sticky until reset.
    logic [TimerWidth-1:0] pwr_tmr_q;
    logic                  powerup_done_q;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            pwr_tmr_q      <= '0;
            powerup_done_q <= 1'b0;
        end else if (us_tick && !powerup_done_q) begin
            if (pwr_tmr_q == PowerupLast) begin
                powerup_done_q <= 1'b1;
            end else begin
                pwr_tmr_q <= pwr_tmr_q + TimerWidth'(1);
            end
        end
    end

    assign o_powerup_done = powerup_done_q;

    logic [NUM_PORTS-1:0] prsnt_n_meta_q, prsnt_n_sync_q;
    logic [NUM_PORTS-1:0] los_meta_q, los_sync_q;
    logic [NUM_PORTS-1:0] fault_meta_q, fault_sync_q;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            prsnt_n_meta_q <= '1;
            prsnt_n_sync_q <= '1;
            los_meta_q     <= '1;
            los_sync_q     <= '1;
            fault_meta_q   <= '0;
            fault_sync_q   <= '0;
        end else begin
            prsnt_n_meta_q <= i_sfp_mod_prsnt_n;
            prsnt_n_sync_q <= prsnt_n_meta_q;
            los_meta_q     <= i_sfp_los;
            los_sync_q     <= los_meta_q;
            fault_meta_q   <= i_sfp_tx_fault;
            fault_sync_q   <= fault_meta_q;
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        port_state_t           state_q, state_d;
        logic [TimerWidth-1:0] tmr_q;
        logic [RetryWidth-1:0] retry_q, retry_d, retry_inc;
        logic                  present, los, tx_fault, ready, link;
        logic                  fault_window, link_timeout;
        logic                  tx_dis, xrst, up, flt;

        assign present      = ~prsnt_n_sync_q[p];
        assign los          = los_sync_q[p];
        assign tx_fault     = fault_sync_q[p];
        assign ready        = i_xcvr_ready[p];
        assign link         = i_link_up[p];
        assign retry_inc    = retry_q + RetryWidth'(1);
        assign link_timeout = us_tick && (tmr_q == LinkTimeoutLast);
        assign fault_window = (state_q == StXcvrReset) || (state_q == StXcvrWait) ||
                              (state_q == StLinkWait)  || (state_q == StUp);

        always_comb begin
            state_d = state_q;
            retry_d = (state_q == StAbsent) ? '0 : retry_q;
            if (state_q != StInit && state_q != StAbsent && !present) begin
                state_d = StAbsent;
            end else if (fault_window && tx_fault) begin
                retry_d = retry_inc;
                state_d = (retry_inc >= RetryLimit) ? StFault : StTxDisable;
            end else begin
                case (state_q)
                    StInit:      if (powerup_done_q) state_d = StAbsent;
                    StAbsent:    if (present) state_d = StTxDisable;
                    StTxDisable: if (us_tick && tmr_q == TxDisableLast) state_d = StXcvrReset;
                    StXcvrReset: if (us_tick && tmr_q == XcvrResetLast) state_d = StXcvrWait;
                    StXcvrWait: begin
                        if (ready)             state_d = StLinkWait;
                        else if (link_timeout) state_d = StXcvrReset;
                    end
                    StLinkWait: begin
                        if (link && !los)      state_d = StUp;
                        else if (link_timeout) state_d = StXcvrReset;
                    end
                    StUp: begin
                        if (!ready)            state_d = StXcvrWait;
                        else if (los || !link) state_d = StLinkWait;
                    end
                    default: ;
                endcase
            end
        end

        // Timer restarts on every state entry; it may wrap harmlessly in untimed states.
        always_ff @(posedge i_clock) begin
            if (i_reset) begin
                state_q <= StInit;
                tmr_q   <= '0;
                retry_q <= '0;
            end else begin
                state_q <= state_d;
                retry_q <= retry_d;
                if (state_d != state_q) begin
                    tmr_q <= '0;
                end else if (us_tick) begin
                    tmr_q <= tmr_q + TimerWidth'(1);
                end
            end
        end

        always_comb begin
            tx_dis = 1'b0;
            xrst   = 1'b0;
            up     = 1'b0;
            flt    = 1'b0;
            case (state_q)
                StInit, StAbsent, StTxDisable: begin
                    tx_dis = 1'b1;
                    xrst   = 1'b1;
                end
                StXcvrReset: xrst = 1'b1;
                StUp:        up   = 1'b1;
                StFault: begin
                    tx_dis = 1'b1;
                    xrst   = 1'b1;
                    flt    = 1'b1;
                end
                default: ;
            endcase
        end

        assign o_sfp_tx_disable[p] = tx_dis;
        assign o_xcvr_reset[p]     = xrst;
        assign o_port_up[p]        = up;
        assign o_port_fault[p]     = flt;
    end

endmodule

// File: tb/tb_sfp_port_bringup_sequencer.sv
// Directed bench for the two-port bring-up sequencer at 10 MHz with shortened delays.
module tb_sfp_port_bringup_sequencer;

    localparam int SelTxDis0 = 0;
    localparam int SelXrst0  = 1;
    localparam int SelUp0    = 2;
    localparam int SelUp1    = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] prsnt_n, los, tx_fault, xcvr_ready, link_up;
    logic [1:0] tx_disable, xcvr_reset, port_up, port_fault;
    logic       powerup_done;
    int         checks = 0;
    int         errors = 0;
    int         n, n1, n2;

    always #50 clk = ~clk;

    sfp_port_bringup_sequencer #(
        .NUM_PORTS        (2),
        .CLOCK_FREQUENCY  (10_000_000),
        .POWERUP_DELAY_US (5),
        .TX_DISABLE_US    (10),
        .XCVR_RESET_US    (1),
        .LINK_TIMEOUT_US  (50),
        .FAULT_RETRY_LIMIT(3)
    ) dut (
        .i_clock          (clk),
        .i_reset          (rst),
        .i_sfp_mod_prsnt_n(prsnt_n),
        .i_sfp_los        (los),
        .i_sfp_tx_fault   (tx_fault),
        .i_xcvr_ready     (xcvr_ready),
        .i_link_up        (link_up),
        .o_sfp_tx_disable (tx_disable),
        .o_xcvr_reset     (xcvr_reset),
        .o_port_up        (port_up),
        .o_port_fault     (port_fault),
        .o_powerup_done   (powerup_done)
    );

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, leaving time just after the last edge.
    task automatic cycles(input int count);
        repeat (count) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic pick(input int sel);
        case (sel)
            SelTxDis0: pick = tx_disable[0];
            SelXrst0:  pick = xcvr_reset[0];
            SelUp0:    pick = port_up[0];
            default:   pick = port_up[1];
        endcase
    endfunction

    task automatic wait_for(input string tag, input int sel, input logic val, input int limit,
                            output int waited);
        waited = 0;
        while (pick(sel) !== val && waited < limit) begin
            cycles(1);
            waited++;
        end
        check_value(tag, 32'(pick(sel)), 32'(val));
    endtask

    // One-cycle pin pulse, returning when the synchronised event has reached the FSM.
    task automatic pulse_fault(input logic [1:0] mask);
        tx_fault = mask;
        cycles(1);
        tx_fault = 2'b00;
        cycles(2);
    endtask

    initial begin
        #(100 * 60_000);
        $display("FAIL watchdog: cycle budget exhausted");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        prsnt_n    = 2'b10;
        los        = 2'b00;
        tx_fault   = 2'b00;
        xcvr_ready = 2'b00;
        link_up    = 2'b00;
        cycles(2);
        check_value("rst_txdis", 32'(tx_disable), 32'h3);
        check_value("rst_xrst", 32'(xcvr_reset), 32'h3);
        check_value("rst_up", 32'(port_up), 32'h0);
        check_value("rst_fault", 32'(port_fault), 32'h0);
        check_value("rst_pwr", 32'(powerup_done), 32'h0);
        rst = 1'b0;

        // Bring-up timeline counted from the last reset edge.
        cycles(49);
        check_value("pwr_early", 32'(powerup_done), 32'h0);
        cycles(1);
        check_value("pwr_done", 32'(powerup_done), 32'h1);
        cycles(99);
        check_value("txdis_149", 32'(tx_disable), 32'h3);
        cycles(1);
        check_value("txdis_150", 32'(tx_disable), 32'h2);
        check_value("xrst_150", 32'(xcvr_reset), 32'h3);
        cycles(9);
        check_value("xrst_159", 32'(xcvr_reset), 32'h3);
        cycles(1);
        check_value("xrst_160", 32'(xcvr_reset), 32'h2);
        cycles(190);
        xcvr_ready[0] = 1'b1;
        check_value("up_before_ready", 32'(port_up), 32'h0);
        cycles(50);
        link_up[0] = 1'b1;
        check_value("up_before_link", 32'(port_up), 32'h0);
        check_value("xrst_link_wait", 32'(xcvr_reset), 32'h2);
        cycles(1);
        check_value("up_401", 32'(port_up), 32'h1);

        // LOS in UP drops the port after three clocks; TX stays enabled.
        los[0] = 1'b1;
        cycles(2);
        check_value("los_up_lat2", 32'(port_up[0]), 32'h1);
        cycles(1);
        check_value("los_up_lat3", 32'(port_up[0]), 32'h0);
        cycles(20);
        check_value("los_txdis", 32'(tx_disable[0]), 32'h0);
        check_value("los_xrst", 32'(xcvr_reset[0]), 32'h0);
        los[0] = 1'b0;
        cycles(3);
        check_value("los_clear_up", 32'(port_up[0]), 32'h1);

        // Three faults: two restarts through a 10 us TX_DISABLE, then latched.
        for (int i = 0; i < 2; i++) begin
            pulse_fault(2'b01);
            check_value("flt_restart_txdis", 32'(tx_disable[0]), 32'h1);
            check_value("flt_restart_nofault", 32'(port_fault[0]), 32'h0);
            wait_for("flt_txdis_fall", SelTxDis0, 1'b0, 150, n);
            check_value("flt_txdis_width", 32'(n >= 91 && n <= 100), 32'h1);
            wait_for("flt_up_again", SelUp0, 1'b1, 300, n);
        end
        pulse_fault(2'b01);
        check_value("flt_latched", 32'(port_fault[0]), 32'h1);
        check_value("flt_txdis", 32'(tx_disable[0]), 32'h1);
        check_value("flt_xrst", 32'(xcvr_reset[0]), 32'h1);
        cycles(200);
        check_value("flt_held", 32'(port_fault[0]), 32'h1);
        check_value("flt_held_up", 32'(port_up[0]), 32'h0);
        prsnt_n[0] = 1'b1;
        cycles(3);
        check_value("flt_removed", 32'(port_fault[0]), 32'h0);

        // No link: XCVR_RESET pulses every 51 us, each 1 us wide, never faulting.
        link_up[0] = 1'b0;
        prsnt_n[0] = 1'b0;
        wait_for("nolink_first_fall", SelXrst0, 1'b0, 300, n);
        wait_for("nolink_rise", SelXrst0, 1'b1, 700, n);
        wait_for("nolink_fall", SelXrst0, 1'b0, 100, n1);
        wait_for("nolink_rise2", SelXrst0, 1'b1, 700, n2);
        check_value("nolink_width", 32'(n1), 32'd10);
        check_value("nolink_period", 32'(n1 + n2), 32'd510);
        check_value("nolink_nofault", 32'(port_fault[0]), 32'h0);

        // Removal and fault together: removal wins and the retry count is cleared.
        link_up[0] = 1'b1;
        wait_for("rf_up0", SelUp0, 1'b1, 700, n);
        for (int i = 0; i < 2; i++) begin
            pulse_fault(2'b01);
            wait_for("rf_up_again", SelUp0, 1'b1, 300, n);
        end
        prsnt_n[0] = 1'b1;
        pulse_fault(2'b01);
        check_value("rf_nofault", 32'(port_fault[0]), 32'h0);
        check_value("rf_absent_txdis", 32'(tx_disable[0]), 32'h1);
        check_value("rf_absent_up", 32'(port_up[0]), 32'h0);
        prsnt_n[0] = 1'b0;
        wait_for("rf_reinsert_up", SelUp0, 1'b1, 300, n);
        pulse_fault(2'b01);
        check_value("rf_count_cleared", 32'(port_fault[0]), 32'h0);
        check_value("rf_restart_txdis", 32'(tx_disable[0]), 32'h1);
        wait_for("rf_up_final", SelUp0, 1'b1, 300, n);

        // Port1 UP while port0 sits in TX_DISABLE, then reset replays everything.
        prsnt_n[1]    = 1'b0;
        xcvr_ready[1] = 1'b1;
        link_up[1]    = 1'b1;
        wait_for("p1_up", SelUp1, 1'b1, 300, n);
        pulse_fault(2'b01);
        check_value("indep_txdis", 32'(tx_disable), 32'h1);
        check_value("indep_up", 32'(port_up), 32'h2);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        check_value("mid_rst_txdis", 32'(tx_disable), 32'h3);
        check_value("mid_rst_xrst", 32'(xcvr_reset), 32'h3);
        check_value("mid_rst_up", 32'(port_up), 32'h0);
        check_value("mid_rst_fault", 32'(port_fault), 32'h0);
        check_value("mid_rst_pwr", 32'(powerup_done), 32'h0);
        cycles(49);
        check_value("replay_pwr_early", 32'(powerup_done), 32'h0);
        cycles(1);
        check_value("replay_pwr_done", 32'(powerup_done), 32'h1);
        cycles(99);
        check_value("replay_txdis_149", 32'(tx_disable), 32'h3);
        cycles(1);
        check_value("replay_txdis_150", 32'(tx_disable), 32'h0);
        wait_for("replay_up0", SelUp0, 1'b1, 300, n);
        wait_for("replay_up1", SelUp1, 1'b1, 300, n);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
